// File: rtl/operand_queue_if.sv
// Operand queue handshake bundle: command, VRF-word and VFU channels plus idle status.
// The master side is the accessor/VFU environment; the slave side is the queue itself.
interface operand_queue_if #(
  parameter int DataWidth = 64,
  parameter int VlWidth   = 16,
  parameter int IdWidth   = 2
);
  localparam int WordB = DataWidth / 8;

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [VlWidth-1:0]   cmd_vlB_i;
  logic [IdWidth-1:0]   cmd_id_i;
  logic                 operand_valid_i;
  logic                 operand_ready_o;
  logic [DataWidth-1:0] operand_i;
  logic                 vfu_valid_o;
  logic                 vfu_ready_i;
  logic [DataWidth-1:0] vfu_data_o;
  logic [WordB-1:0]     vfu_strb_o;
  logic                 vfu_last_o;
  logic [IdWidth-1:0]   vfu_id_o;
  logic                 idle_o;

  modport master (
    output cmd_valid_i, cmd_vlB_i, cmd_id_i, operand_valid_i, operand_i, vfu_ready_i,
    input  cmd_ready_o, operand_ready_o, vfu_valid_o, vfu_data_o, vfu_strb_o,
           vfu_last_o, vfu_id_o, idle_o
  );

  modport slave (
    input  cmd_valid_i, cmd_vlB_i, cmd_id_i, operand_valid_i, operand_i, vfu_ready_i,
    output cmd_ready_o, operand_ready_o, vfu_valid_o, vfu_data_o, vfu_strb_o,
           vfu_last_o, vfu_id_o, idle_o
  );
endinterface

// File: rtl/operand_queue.sv
// Per-lane operand buffer: VRF words queued against per-instruction byte lengths, presented
// to the VFU with tail strobe, last flag and id. Registered storage, no fall-through or bypass.
module operand_queue #(
  parameter int DataWidth = 64,
  parameter int Depth     = 4,
  parameter int CmdDepth  = 2,
  parameter int VlWidth   = 16,
  parameter int IdWidth   = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  operand_queue_if.slave bus
);
  localparam int WordB    = DataWidth / 8;
  localparam int PtrW     = $clog2(Depth);
  localparam int CmdPtrW  = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int CntW     = $clog2(Depth + 1);
  localparam int CmdCntW  = $clog2(CmdDepth + 1);

  logic [DataWidth-1:0] op_mem_q [Depth];
  logic [PtrW-1:0]      op_wr_q, op_wr_d, op_rd_q, op_rd_d;
  logic [CntW-1:0]      op_cnt_q, op_cnt_d;

  logic [VlWidth-1:0]   cmd_vlb_mem_q [CmdDepth];
  logic [IdWidth-1:0]   cmd_id_mem_q  [CmdDepth];
  logic [CmdPtrW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CmdCntW-1:0]   cmd_cnt_q, cmd_cnt_d;

  logic [VlWidth-1:0]   consumed_q, consumed_d;

  logic                 op_push, op_pop, cmd_hs, cmd_push, cmd_pop, cmd_nonempty;
  logic                 vfu_valid, last;
  logic [VlWidth-1:0]   head_vlb, remain;
  logic [WordB-1:0]     strb;

  function automatic logic [PtrW-1:0] op_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CmdPtrW-1:0] cmd_inc(input logic [CmdPtrW-1:0] p);
    return (p == CmdPtrW'(CmdDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.operand_ready_o = (op_cnt_q != CntW'(Depth));
  assign bus.cmd_ready_o     = (cmd_cnt_q != CmdCntW'(CmdDepth));
  assign op_push             = bus.operand_valid_i && bus.operand_ready_o;
  assign cmd_hs              = bus.cmd_valid_i && bus.cmd_ready_o;
  // Zero-length instructions complete the handshake but deliver nothing on this lane.
  assign cmd_push            = cmd_hs && (bus.cmd_vlB_i != '0);
  assign cmd_nonempty        = (cmd_cnt_q != '0);
  assign head_vlb            = cmd_vlb_mem_q[cmd_rd_q];
  assign vfu_valid           = (op_cnt_q != '0) && cmd_nonempty;
  assign remain              = head_vlb - consumed_q;
  assign last                = (remain <= VlWidth'(WordB));
  assign op_pop              = vfu_valid && bus.vfu_ready_i;
  assign cmd_pop             = op_pop && last;

  always_comb begin
    strb = '0;
    for (int b = 0; b < WordB; b++) strb[b] = (remain > VlWidth'(b));
  end

  assign bus.vfu_valid_o = vfu_valid;
  assign bus.vfu_data_o  = vfu_valid ? op_mem_q[op_rd_q] : '0;
  assign bus.vfu_strb_o  = vfu_valid ? strb : '0;
  assign bus.vfu_last_o  = vfu_valid && last;
  assign bus.vfu_id_o    = cmd_nonempty ? cmd_id_mem_q[cmd_rd_q] : '0;
  assign bus.idle_o      = (op_cnt_q == '0) && !cmd_nonempty;

  always_comb begin
    op_wr_d    = op_push ? op_inc(op_wr_q) : op_wr_q;
    op_rd_d    = op_pop ? op_inc(op_rd_q) : op_rd_q;
    op_cnt_d   = op_cnt_q;
    cmd_wr_d   = cmd_push ? cmd_inc(cmd_wr_q) : cmd_wr_q;
    cmd_rd_d   = cmd_pop ? cmd_inc(cmd_rd_q) : cmd_rd_q;
    cmd_cnt_d  = cmd_cnt_q;
    consumed_d = consumed_q;
    if (op_push && !op_pop) op_cnt_d = op_cnt_q + 1'b1;
    if (!op_push && op_pop) op_cnt_d = op_cnt_q - 1'b1;
    if (cmd_push && !cmd_pop) cmd_cnt_d = cmd_cnt_q + 1'b1;
    if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - 1'b1;
    if (cmd_pop)     consumed_d = '0;
    else if (op_pop) consumed_d = consumed_q + VlWidth'(WordB);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_wr_q    <= '0;
      op_rd_q    <= '0;
      op_cnt_q   <= '0;
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      consumed_q <= '0;
    end else begin
      op_wr_q    <= op_wr_d;
      op_rd_q    <= op_rd_d;
      op_cnt_q   <= op_cnt_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      consumed_q <= consumed_d;
    end
  end

  // Storage is qualified by the counters, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (op_push && !rst_i) op_mem_q[op_wr_q] <= bus.operand_i;
    if (cmd_push && !rst_i) begin
      cmd_vlb_mem_q[cmd_wr_q] <= bus.cmd_vlB_i;
      cmd_id_mem_q[cmd_wr_q]  <= bus.cmd_id_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    op_push |-> (op_cnt_q < CntW'(Depth)));
  a_consumed_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    cmd_nonempty |-> (consumed_q < head_vlb));
endmodule
